// File: rtl/blake2_msg_feeder_if.sv
// Stream, core byte-load and digest signals of the BLAKE2 message feeder.
// The feeder connects through the slave modport. The driving environment uses the master modport.
interface blake2_msg_feeder_if #(
  parameter int W  = 32,
  parameter int BB = 64
);
  localparam int KW = $clog2(W + 1);
  localparam int IW = $clog2(BB);

  logic              start_i;
  logic [KW-1:0]     kk_i;
  logic [KW-1:0]     nn_i;
  logic              empty_i;
  logic              s_v_i;
  logic [7:0]        s_data_i;
  logic              s_last_i;
  logic              s_ready_o;
  logic              core_ready_i;
  logic              core_data_v_o;
  logic [IW-1:0]     core_data_idx_o;
  logic [7:0]        core_data_o;
  logic              core_block_first_o;
  logic              core_block_last_o;
  logic [KW-1:0]     core_kk_o;
  logic [KW-1:0]     core_nn_o;
  logic [2*W-1:0]    core_ll_o;
  logic              core_h_v_i;
  logic [7:0]        core_h_i;
  logic              dig_v_o;
  logic [7:0]        dig_o;
  logic              dig_last_o;
  logic              busy_o;

  modport slave (
    input  start_i, kk_i, nn_i, empty_i, s_v_i, s_data_i, s_last_i,
           core_ready_i, core_h_v_i, core_h_i,
    output s_ready_o, core_data_v_o, core_data_idx_o, core_data_o,
           core_block_first_o, core_block_last_o, core_kk_o, core_nn_o,
           core_ll_o, dig_v_o, dig_o, dig_last_o, busy_o
  );

  modport master (
    output start_i, kk_i, nn_i, empty_i, s_v_i, s_data_i, s_last_i,
           core_ready_i, core_h_v_i, core_h_i,
    input  s_ready_o, core_data_v_o, core_data_idx_o, core_data_o,
           core_block_first_o, core_block_last_o, core_kk_o, core_nn_o,
           core_ll_o, dig_v_o, dig_o, dig_last_o, busy_o
  );
endinterface

// File: rtl/blake2_msg_feeder.sv
// BLAKE2 byte-stream front end. It blocks the key and the message into zero-padded BB-byte blocks
// for the core, then returns the core's serial digest with the lead-in beat removed.
module blake2_msg_feeder #(
  parameter int W  = 32,
  parameter int BB = 64
) (
  input logic               clk,
  input logic               nreset,
  blake2_msg_feeder_if.slave bus
);
  localparam int KW = $clog2(W + 1);
  localparam int IW = $clog2(BB);
  localparam int LW = 2 * W;
  localparam int CW = ((KW > IW) ? KW : IW) + 1;

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] KEY      = 3'd1;
  localparam logic [2:0] MSG      = 3'd2;
  localparam logic [2:0] PAD      = 3'd3;
  localparam logic [2:0] WAIT_RES = 3'd4;
  localparam logic [2:0] RES      = 3'd5;

  localparam logic [IW-1:0] IDX_LAST = IW'(BB - 1);

  logic [2:0]    state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          first_q, first_d;
  logic          last_q, last_d;
  logic          empty_q, empty_d;
  logic [KW-1:0] kk_q, kk_d;
  logic [KW-1:0] nn_q, nn_d;
  logic [LW-1:0] ll_q, ll_d;
  logic [KW-1:0] dig_cnt_q, dig_cnt_d;
  logic          dig_v_q, dig_v_d;
  logic [7:0]    dig_q, dig_d;
  logic          dig_last_q, dig_last_d;

  logic          s_ready_s;
  logic          core_v_s;
  logic [7:0]    core_data_s;
  logic          blk_end_s;
  logic          key_last_s;

  // Datapath to the core: stream bytes pass straight through, and PAD issues zeros.
  always_comb begin
    s_ready_s   = ((state_q == KEY) || (state_q == MSG)) && bus.core_ready_i;
    core_v_s    = 1'b0;
    core_data_s = 8'h00;
    case (state_q)
      KEY, MSG: begin
        core_v_s    = bus.s_v_i && s_ready_s;
        core_data_s = bus.s_data_i;
      end
      PAD: begin
        core_v_s    = bus.core_ready_i;
        core_data_s = 8'h00;
      end
      default: begin
        core_v_s    = 1'b0;
        core_data_s = 8'h00;
      end
    endcase
    blk_end_s  = core_v_s && (idx_q == IDX_LAST);
    // Key bytes always start at index 0, so the block index doubles as the key byte counter.
    key_last_s = ((CW'(idx_q) + CW'(1)) == CW'(kk_q));
  end

  // Next-state logic for the control FSM, block position, length and digest capture.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    first_d    = first_q;
    last_d     = last_q;
    empty_d    = empty_q;
    kk_d       = kk_q;
    nn_d       = nn_q;
    ll_d       = ll_q;
    dig_cnt_d  = dig_cnt_q;
    dig_v_d    = 1'b0;
    dig_d      = dig_q;
    dig_last_d = 1'b0;

    if (core_v_s) begin
      idx_d = blk_end_s ? {IW{1'b0}} : (idx_q + IW'(1));
      if (blk_end_s) begin
        first_d = 1'b0;
      end else begin
        first_d = first_q;
      end
    end else begin
      idx_d = idx_q;
    end

    case (state_q)
      IDLE: begin
        if (bus.start_i) begin
          kk_d      = bus.kk_i;
          nn_d      = bus.nn_i;
          empty_d   = bus.empty_i;
          idx_d     = {IW{1'b0}};
          first_d   = 1'b1;
          last_d    = 1'b0;
          dig_cnt_d = {KW{1'b0}};
          ll_d      = (bus.kk_i != KW'(0)) ? LW'(BB) : {LW{1'b0}};
          if (bus.kk_i != KW'(0)) begin
            state_d = KEY;
            last_d  = bus.empty_i;
          end else if (bus.empty_i) begin
            state_d = PAD;
            last_d  = 1'b1;
          end else begin
            state_d = MSG;
          end
        end else begin
          state_d = IDLE;
        end
      end
      KEY: begin
        if (core_v_s && key_last_s) begin
          if (blk_end_s) begin
            state_d = empty_q ? WAIT_RES : MSG;
          end else begin
            state_d = PAD;
          end
        end else begin
          state_d = KEY;
        end
      end
      MSG: begin
        if (core_v_s) begin
          ll_d = ll_q + LW'(1);
          if (bus.s_last_i) begin
            last_d  = 1'b1;
            state_d = blk_end_s ? WAIT_RES : PAD;
          end else begin
            state_d = MSG;
          end
        end else begin
          state_d = MSG;
        end
      end
      PAD: begin
        if (blk_end_s) begin
          state_d = last_q ? WAIT_RES : MSG;
        end else begin
          state_d = PAD;
        end
      end
      WAIT_RES: begin
        if (bus.core_h_v_i) begin
          state_d   = RES;
          dig_cnt_d = {KW{1'b0}};
        end else begin
          state_d = WAIT_RES;
        end
      end
      RES: begin
        if (bus.core_h_v_i) begin
          dig_v_d   = 1'b1;
          dig_d     = bus.core_h_i;
          dig_cnt_d = dig_cnt_q + KW'(1);
          if (dig_cnt_q == (nn_q - KW'(1))) begin
            dig_last_d = 1'b1;
            state_d    = IDLE;
          end else begin
            state_d = RES;
          end
        end else begin
          state_d = RES;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      state_q    <= IDLE;
      idx_q      <= {IW{1'b0}};
      first_q    <= 1'b0;
      last_q     <= 1'b0;
      empty_q    <= 1'b0;
      kk_q       <= {KW{1'b0}};
      nn_q       <= {KW{1'b0}};
      ll_q       <= {LW{1'b0}};
      dig_cnt_q  <= {KW{1'b0}};
      dig_v_q    <= 1'b0;
      dig_q      <= 8'h00;
      dig_last_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      first_q    <= first_d;
      last_q     <= last_d;
      empty_q    <= empty_d;
      kk_q       <= kk_d;
      nn_q       <= nn_d;
      ll_q       <= ll_d;
      dig_cnt_q  <= dig_cnt_d;
      dig_v_q    <= dig_v_d;
      dig_q      <= dig_d;
      dig_last_q <= dig_last_d;
    end
  end

  assign bus.s_ready_o          = s_ready_s;
  assign bus.core_data_v_o      = core_v_s;
  assign bus.core_data_idx_o    = idx_q;
  assign bus.core_data_o        = core_data_s;
  assign bus.core_block_first_o = first_q;
  // The final byte's own s_last makes the flag valid on byte BB-1 before last_q is set.
  assign bus.core_block_last_o  = last_q || ((state_q == MSG) && bus.s_v_i && bus.s_last_i);
  assign bus.core_kk_o          = kk_q;
  assign bus.core_nn_o          = nn_q;
  assign bus.core_ll_o          = ll_q;
  assign bus.dig_v_o            = dig_v_q;
  assign bus.dig_o              = dig_q;
  assign bus.dig_last_o         = dig_last_q;
  assign bus.busy_o             = (state_q != IDLE);
endmodule

// File: tb/tb_blake2_msg_feeder.sv
// Directed bench for blake2_msg_feeder. It logs the core byte stream and the digest beats,
// then compares them against a reference built from the test parameters.
module tb_blake2_msg_feeder;
  localparam int W  = 32;
  localparam int BB = 64;

  logic clk = 1'b0;
  logic nreset;
  always #5 clk = ~clk;

  blake2_msg_feeder_if #(.W(W), .BB(BB)) bus ();
  blake2_msg_feeder #(.W(W), .BB(BB)) dut (.clk(clk), .nreset(nreset), .bus(bus));

  typedef struct packed {
    logic [5:0] idx;
    logic [7:0] data;
    logic       first;
    logic       last;
  } beat_t;
  typedef struct packed {
    logic [7:0] d;
    logic       last;
    logic       busy;
  } dig_t;

  beat_t clog[$];
  dig_t  dlog[$];
  int    checks = 0;
  int    errors = 0;
  int    hs_cnt = 0;
  int    gap_viol = 0;
  int    gap_len = 1;
  int    gap_cnt = 0;
  bit    gap_pending = 1'b0;
  bit    ready_en = 1'b0;

  assign bus.core_ready_i = ready_en && (gap_cnt == 0);

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] all_outs();
    return {23'd0, bus.s_ready_o, bus.core_data_v_o, bus.core_data_idx_o, bus.core_data_o,
            bus.core_block_first_o, bus.core_block_last_o, bus.core_kk_o, bus.core_nn_o,
            bus.core_ll_o, bus.dig_v_o, bus.dig_o, bus.dig_last_o, bus.busy_o};
  endfunction

  function automatic logic [7:0] msg_byte(input bit abc, input int i);
    if (abc) return 8'h61 + 8'(i);
    else     return 8'(i * 7 + 1);
  endfunction

  // Monitor: samples on the falling edge what the DUT commits on the next rising edge.
  initial forever begin
    @(negedge clk);
    if (bus.core_data_v_o) begin
      clog.push_back('{bus.core_data_idx_o, bus.core_data_o,
                       bus.core_block_first_o, bus.core_block_last_o});
      if (bus.core_data_idx_o == 6'd63) gap_pending = 1'b1;
    end
    if (bus.core_data_v_o && !bus.core_ready_i) gap_viol++;
    if (bus.s_v_i && bus.s_ready_o) hs_cnt++;
    if (bus.dig_v_o) dlog.push_back('{bus.dig_o, bus.dig_last_o, bus.busy_o});
  end

  // Core model for ready: ready drops for gap_len cycles after each block's last byte.
  initial forever begin
    @(posedge clk);
    #1;
    if (gap_pending) begin
      gap_cnt     = gap_len;
      gap_pending = 1'b0;
    end else if (gap_cnt > 0) begin
      gap_cnt = gap_cnt - 1;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic last);
    bit acc = 1'b0;
    int t = 0;
    bus.s_v_i    = 1'b1;
    bus.s_data_i = d;
    bus.s_last_i = last;
    while (!acc && t < 300) begin
      @(negedge clk);
      acc = bus.s_ready_o;
      step(1);
      t++;
    end
    bus.s_v_i    = 1'b0;
    bus.s_last_i = 1'b0;
    bus.s_data_i = 8'h00;
    if (!acc) check("stream_timeout", 128'd0, 128'd1);
  endtask

  task automatic do_start(input int kk, input int nn, input bit empty);
    bus.start_i = 1'b1;
    bus.kk_i    = 6'(kk);
    bus.nn_i    = 6'(nn);
    bus.empty_i = empty;
    step(1);
    bus.start_i = 1'b0;
    bus.kk_i    = 6'd0;
    bus.nn_i    = 6'd0;
    bus.empty_i = 1'b0;
  endtask

  task automatic run_case(input string nm, input int kk, input int nn, input bit empty,
                          input int mlen, input bit abc, input int gap);
    int pre, total, plast, t, n, b_idx, b_dat, b_first, b_last, d_dat, d_last;
    logic [7:0] ed;
    pre   = (kk > 0) ? BB : 0;
    total = empty ? BB : (((pre + mlen + BB - 1) / BB) * BB);
    plast = pre + mlen - 1;
    clog.delete();
    dlog.delete();
    hs_cnt   = 0;
    gap_viol = 0;
    gap_len  = gap;

    do_start(kk, nn, empty);
    @(negedge clk);
    check({nm, " busy_rise"}, 128'(bus.busy_o), 128'd1);
    check({nm, " kk_nn"}, 128'({bus.core_kk_o, bus.core_nn_o}), 128'({6'(kk), 6'(nn)}));
    step(1);

    for (int i = 0; i < kk; i++) send_byte(8'h80 + 8'(i), 1'b0);
    if (!empty) begin
      for (int i = 0; i < mlen; i++) send_byte(msg_byte(abc, i), (i == mlen - 1));
    end
    t = 0;
    while (clog.size() < total && t < 2000) begin
      step(1);
      t++;
    end
    step(3);
    @(negedge clk);
    check({nm, " core_bytes"}, 128'(clog.size()), 128'(total));
    check({nm, " ll"}, 128'(bus.core_ll_o), 128'(pre + (empty ? 0 : mlen)));
    check({nm, " handshakes"}, 128'(hs_cnt), 128'(kk + (empty ? 0 : mlen)));
    check({nm, " gap_issue"}, 128'(gap_viol), 128'd0);

    b_idx = 0; b_dat = 0; b_first = 0; b_last = 0;
    n = (clog.size() < total) ? clog.size() : total;
    for (int p = 0; p < n; p++) begin
      if (p < pre)               ed = (p < kk) ? (8'h80 + 8'(p)) : 8'h00;
      else if (p - pre < mlen)   ed = msg_byte(abc, p - pre);
      else                       ed = 8'h00;
      if (empty && p < pre)      ed = (p < kk) ? (8'h80 + 8'(p)) : 8'h00;
      if (empty && kk == 0)      ed = 8'h00;
      if (clog[p].idx != 6'(p % BB))             b_idx++;
      if (clog[p].data != ed)                    b_dat++;
      if (clog[p].first != (p < BB))             b_first++;
      if (clog[p].last != (empty ? 1'b1 : (p >= plast))) b_last++;
    end
    check({nm, " idx_seq"}, 128'(b_idx), 128'd0);
    check({nm, " data_seq"}, 128'(b_dat), 128'd0);
    check({nm, " first_flag"}, 128'(b_first), 128'd0);
    check({nm, " last_flag"}, 128'(b_last), 128'd0);

    step(1);
    bus.core_h_v_i = 1'b1;
    bus.core_h_i   = 8'h5A;
    step(1);
    for (int j = 1; j <= nn; j++) begin
      bus.core_h_i = 8'hC0 + 8'(j);
      step(1);
    end
    bus.core_h_v_i = 1'b0;
    bus.core_h_i   = 8'h00;
    step(3);
    @(negedge clk);
    check({nm, " dig_count"}, 128'(dlog.size()), 128'(nn));
    d_dat = 0; d_last = 0;
    for (int k = 0; k < dlog.size(); k++) begin
      if (dlog[k].d != (8'hC1 + 8'(k))) d_dat++;
      if (dlog[k].last != (k == nn - 1)) d_last++;
    end
    check({nm, " dig_data"}, 128'(d_dat), 128'd0);
    check({nm, " dig_last"}, 128'(d_last), 128'd0);
    if (dlog.size() > 1) check({nm, " busy_before_last"}, 128'(dlog[dlog.size()-2].busy), 128'd1);
    if (dlog.size() > 0) check({nm, " busy_at_last"}, 128'(dlog[dlog.size()-1].busy), 128'd0);
    check({nm, " idle_after"}, 128'(bus.busy_o), 128'd0);
    step(1);
  endtask

  initial begin
    nreset          = 1'b0;
    ready_en        = 1'b1;
    bus.start_i     = 1'b0;
    bus.kk_i        = 6'd0;
    bus.nn_i        = 6'd0;
    bus.empty_i     = 1'b0;
    bus.s_v_i       = 1'b0;
    bus.s_data_i    = 8'h00;
    bus.s_last_i    = 1'b0;
    bus.core_h_v_i  = 1'b0;
    bus.core_h_i    = 8'h00;
    step(3);
    @(negedge clk);
    check("reset_outputs", all_outs(), 128'd0);
    step(1);
    nreset = 1'b1;
    step(2);

    run_case("abc",        0, 32, 1'b0,  3, 1'b1,  1);
    run_case("empty",      0, 32, 1'b1,  0, 1'b0,  1);
    run_case("full64",     0, 16, 1'b0, 64, 1'b0,  1);
    run_case("gap65",      0, 32, 1'b0, 65, 1'b0, 10);
    run_case("key_empty", 32, 32, 1'b1,  0, 1'b0,  1);
    run_case("key_abc",   32, 20, 1'b0,  3, 1'b1,  1);

    // Reset in the middle of padding, then a clean rerun.
    clog.delete();
    do_start(0, 32, 1'b0);
    for (int i = 0; i < 3; i++) send_byte(msg_byte(1'b1, i), (i == 2));
    step(5);
    @(negedge clk);
    check("pre_reset_busy", 128'(bus.busy_o), 128'd1);
    step(1);
    nreset = 1'b0;
    step(1);
    @(negedge clk);
    check("mid_reset_outputs", all_outs(), 128'd0);
    step(1);
    nreset = 1'b1;
    step(2);
    run_case("abc_again", 0, 32, 1'b0, 3, 1'b1, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/blake2_msg_feeder.md
# blake2_msg_feeder

Byte-stream front end for the BLAKE2 hash core. It takes an optional key and a message as a valid/ready byte stream, cuts them into BB-byte blocks with key and tail zero padding, and drives the core's byte-load interface. That interface is: byte index, first/last block flags, `kk`, `nn` and total length `ll`. It then collects the core's serial result, drops the core's lead-in beat and presents exactly `nn` digest bytes with a last marker.

## Interface
- `W`, 32: core word width in bits; sets the `kk`/`nn` width `KW = $clog2(W+1)` and the `ll` width `2*W`.
- `BB`, 64: block size in bytes; index width `IW = $clog2(BB)`.
- `clk` in 1: clock.
- `nreset` in 1: reset, synchronous, active-low.
- `start_i` in 1: begin a hash. Ignored unless idle.
- `kk_i` in KW: key length in bytes, 0..W. Latched on `start_i`.
- `nn_i` in KW: digest length in bytes, 1..W. Latched on `start_i`.
- `empty_i` in 1: message has zero bytes. Latched on `start_i`.
- `s_v_i` in 1: stream byte valid. Key bytes come first, then message bytes.
- `s_data_i` in 8: stream byte.
- `s_last_i` in 1: final message byte. Ignored on key bytes.
- `s_ready_o` out 1: stream byte accepted when `s_v_i & s_ready_o`.
- `core_ready_i` in 1: core is able to take a byte this cycle.
- `core_data_v_o` out 1: byte valid to the core.
- `core_data_idx_o` out IW: byte index within the block.
- `core_data_o` out 8: byte to the core.
- `core_block_first_o` out 1: the current block is the first block.
- `core_block_last_o` out 1: the current block is the final block.
- `core_kk_o` out KW: latched `kk`.
- `core_nn_o` out KW: latched `nn`.
- `core_ll_o` out 2W: total byte count.
- `core_h_v_i` in 1: core result beat valid.
- `core_h_i` in 8: core result byte.
- `dig_v_o` out 1: digest byte valid.
- `dig_o` out 8: digest byte.
- `dig_last_o` out 1: digest byte `nn-1`.
- `busy_o` out 1: high whenever the state is not `IDLE`.

## Operation
- **States:** `IDLE`, `KEY`, `MSG`, `PAD`, `WAIT_RES`, `RES`.
- **From `IDLE` on `start_i`:**
  - latch `kk`, `nn`, `empty`;
  - set `idx = 0`, `first_q = 1`, `last_q = 0`;
  - set `ll_q = (kk != 0) ? BB : 0`;
  - next state: `KEY` if `kk > 0`; else `PAD` with `last_q = 1` if `empty`; else `MSG`.
- **`KEY`:** forward `kk` key bytes.
  - After key byte `kk-1`, go to `PAD` if `idx != BB-1`; otherwise treat the block as complete.
  - Key bytes do not advance `ll_q`.
  - If `empty`, the key block is the last block: `last_q = 1` on entry to `KEY`.
- **`MSG`:** forward message bytes. Each accepted byte advances `ll_q` by 1 (wraps mod 2^(2W)).
  - Byte accepted with `s_last_i`: set `last_q`. Go to `PAD` if `idx != BB-1`, else to `WAIT_RES`.
- **`PAD`:** drive zero bytes whenever `core_ready_i`, until `idx = BB-1` is sent.
  - Then go to `WAIT_RES` if `last_q`, else to `MSG`. The else case is key padding followed by a message.
- **Block completion (any state):** when `idx = BB-1` is sent, `idx` wraps to 0, `first_q` clears and `last_q` holds.
  - Leaving `KEY` at a full block with no message: go to `WAIT_RES`.
- **`core_block_first_o`** = `first_q`.
- **`core_block_last_o`** = `last_q | (MSG & s_v_i & s_last_i)`. The flag is therefore correct on byte BB-1 of the final block, which is the value the core latches.
- **`WAIT_RES` → `RES`:** on the first `core_h_v_i` beat. That lead-in beat is dropped.
- **`RES`:** each `core_h_v_i` beat is forwarded as `dig_v_o`/`dig_o`; a digest counter counts `0..nn-1`.
  - `dig_last_o` is high on count `nn-1`, after which the state goes to `IDLE`.
- **Mid-operation reset:** `nreset` low returns the block to `IDLE`, clears all counters and flags, and zeroes all outputs. The core shares `nreset`.

## Timing
- **Reset values:** `s_ready_o`, `core_data_v_o`, `core_block_first_o`, `core_block_last_o`, `dig_v_o`, `dig_last_o` and `busy_o` are 0. `core_data_idx_o`, `core_ll_o`, `core_kk_o`, `core_nn_o`, `dig_o` and `core_data_o` are 0.
- **Stream ready:** `s_ready_o = (KEY | MSG) & core_ready_i`. Combinational, zero-latency pass-through.
- **Core valid:**
  - `KEY`/`MSG`: `core_data_v_o = s_v_i & s_ready_o`, `core_data_o = s_data_i`.
  - `PAD`: `core_data_v_o = core_ready_i`, `core_data_o = 0`.
- **Block boundary:** the core drops `core_ready_i` the cycle after byte BB-1. No byte is issued while `core_ready_i = 0`. Stalls inside a block are allowed.
- **Length:** `core_ll_o = ll_q` is registered and updates the cycle after the accept. It holds from the final byte until the state returns to `IDLE`.
- **Digest:** `dig_*` are registered, one cycle after `core_h_v_i`.
- **Start timing:** `start_i` is accepted the same cycle `busy_o` would otherwise be 0. `busy_o` rises the next cycle.

## Test plan
- **Unkeyed "abc", `nn=32`:** 3 data bytes, then 61 zero pad bytes at idx 0..63, `first = last = 1`, `ll = 3`. Of the 33 core beats, the first is dropped and 32 are forwarded; `dig_last_o` is on the 32nd; `busy_o` falls the next cycle.
- **`empty_i = 1`, `kk = 0`:** 64 zero bytes, `first = last = 1`, `ll = 0`. No stream handshake occurs.
- **Exactly 64 bytes, `s_last_i` on byte 64:** one block, `core_block_last_o` high only at idx 63, no extra block, `ll = 64`.
- **65 bytes with `core_ready_i` low for 10 cycles after idx 63:**
  - no `core_data_v_o` during the gap;
  - block 1: 1 byte plus 63 pads, `first = 0`, `last = 1`;
  - `ll = 65`.
- **`kk = 32`:**
  - `empty = 1`: 32 key bytes plus 32 zeros, `first = last = 1`, `ll = 64`;
  - 3-byte message: key block `first = 1` `last = 0`, then message block `last = 1`, `ll = 67`.
- **`nreset` low mid-`PAD`:** next cycle all outputs are 0 and the state is `IDLE`. A fresh `start_i` then runs the "abc" case correctly.
